// File: rtl/sound_mixer.sv
// sound_mixer: N-channel PSG/FM sample mixer.
// On each sample strobe the channel samples, enables and gains are
// snapshotted, then one channel per clock is multiplied by its gain and
// accumulated. The result is scaled back by the unity gain, saturated to
// OUT_W bits and presented with a one-cycle valid pulse and a clip flag.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   sample_stb   start mixing one sample (single-cycle pulse)
//   ch_in        packed signed samples, channel i at [i*IN_W +: IN_W]
//   ch_en        per-channel enable mask
//   cfg_we       gain register write strobe
//   cfg_addr     gain register index (out-of-range writes ignored)
//   cfg_data     gain value, unity = 2^(GAIN_W-1)
//   sound        registered signed mixed sample (holds between samples)
//   sound_valid  one-cycle pulse when sound updates
//   clip         saturation occurred in the current sample
//   busy         accumulation in progress
//   overrun      sample_stb arrived while not idle and was dropped
//
// state | meaning
// IDLE  | waiting for sample_stb
// ACCUM | one channel multiply-accumulated per clock
// OUT   | sound/clip/sound_valid presented for one cycle
module sound_mixer #(
    parameter int CHANNELS = 4,
    parameter int IN_W     = 16,
    parameter int GAIN_W   = 8,
    parameter int OUT_W    = 16,
    localparam int AW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_stb,
    input  logic [CHANNELS*IN_W-1:0] ch_in,
    input  logic [CHANNELS-1:0]      ch_en,
    input  logic                     cfg_we,
    input  logic [AW-1:0]            cfg_addr,
    input  logic [GAIN_W-1:0]        cfg_data,
    output logic [OUT_W-1:0]         sound,
    output logic                     sound_valid,
    output logic                     clip,
    output logic                     busy,
    output logic                     overrun
);

    localparam int ACC_W  = IN_W + GAIN_W + $clog2(CHANNELS) + 1;
    localparam int PROD_W = IN_W + GAIN_W + 1;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = {1'b1, {(GAIN_W-1){1'b0}}};
    localparam logic [AW-1:0] LAST_IDX = AW'(CHANNELS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) <<< (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t                    state;
    logic [AW-1:0]             idx;
    logic signed [ACC_W-1:0]   acc;
    logic                      busy_r;
    logic [GAIN_W-1:0]         gain   [CHANNELS];
    logic [GAIN_W-1:0]         gain_s [CHANNELS];
    logic signed [IN_W-1:0]    in_s   [CHANNELS];
    logic [CHANNELS-1:0]       en_s;

    logic signed [PROD_W-1:0]  in_x;
    logic signed [PROD_W-1:0]  gain_x;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   term;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   scaled;
    logic [OUT_W-1:0]          sat_val;
    logic                      sat_clip;

    // Gain registers: writable in any state; the running sample uses its own snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) gain[i] <= GAIN_UNITY;
        end else if (cfg_we && (32'(cfg_addr) < CHANNELS)) begin
            gain[cfg_addr] <= cfg_data;
        end
    end

    // Signed sample times zero-extended gain; both operands widened to the
    // product width so the multiply itself is exact.
    always_comb begin
        in_x    = PROD_W'(in_s[idx]);
        gain_x  = $signed({{(PROD_W-GAIN_W){1'b0}}, gain_s[idx]});
        prod    = in_x * gain_x;
        term    = en_s[idx] ? ACC_W'(prod) : '0;
        acc_sum = acc + term;
        scaled  = acc_sum >>> (GAIN_W - 1);
        sat_val  = scaled[OUT_W-1:0];
        sat_clip = 1'b0;
        if (scaled > SAT_MAX) begin
            sat_val  = SAT_MAX[OUT_W-1:0];
            sat_clip = 1'b1;
        end else if (scaled < SAT_MIN) begin
            sat_val  = SAT_MIN[OUT_W-1:0];
            sat_clip = 1'b1;
        end
    end

    // Output is registered on the last ACCUM cycle so it is visible
    // during OUT, giving valid CHANNELS+1 cycles after the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            acc         <= '0;
            busy_r      <= 1'b0;
            en_s        <= '0;
            sound       <= '0;
            sound_valid <= 1'b0;
            clip        <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                gain_s[i] <= GAIN_UNITY;
                in_s[i]   <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    sound_valid <= 1'b0;
                    if (sample_stb) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            gain_s[i] <= gain[i];
                            in_s[i]   <= ch_in[i*IN_W +: IN_W];
                        end
                        en_s   <= ch_en;
                        acc    <= '0;
                        idx    <= '0;
                        busy_r <= 1'b1;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc_sum;
                    if (idx == LAST_IDX) begin
                        sound       <= sat_val;
                        clip        <= sat_clip;
                        sound_valid <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= OUT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                OUT: begin
                    sound_valid <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    sound_valid <= 1'b0;
                    busy_r      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign overrun = sample_stb && (state != IDLE);

endmodule

// File: tb/tb_sound_mixer.sv
module tb_sound_mixer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_stb;
    logic [63:0] ch_in;
    logic [3:0]  ch_en;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic [15:0] sound;
    logic        sound_valid;
    logic        clip;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int gm [4];

    sound_mixer #(.CHANNELS(4), .IN_W(16), .GAIN_W(8), .OUT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .sample_stb(sample_stb), .ch_in(ch_in),
        .ch_en(ch_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .sound(sound), .sound_valid(sound_valid), .clip(clip), .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic logic [63:0] pack4(input int a3, input int a2, input int a1, input int a0);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    // Reference: weighted sum of enabled channels, divided by unity gain with
    // floor rounding, then clamped to the 16-bit signed range.
    function automatic void model(input logic [63:0] ch, input logic [3:0] en,
                                  output logic signed [15:0] s, output logic c);
        longint sum = 0;
        longint q;
        for (int i = 0; i < 4; i++)
            if (en[i]) sum += longint'($signed(ch[i*16 +: 16])) * longint'(gm[i]);
        q = sum / 128;
        if (sum < 0 && (sum % 128) != 0) q = q - 1;
        if (q > 32767) begin s = 16'sd32767; c = 1'b1; end
        else if (q < -32768) begin s = -16'sd32768; c = 1'b1; end
        else begin s = 16'(q); c = 1'b0; end
    endfunction

    task automatic write_gain(input int a, input int d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 2'(a); cfg_data = 8'(d);
        @(negedge clk);
        cfg_we = 1'b0;
        gm[a] = d;
    endtask

    task automatic do_sample(input string nm, input logic [63:0] ch, input logic [3:0] en,
                             input logic we, input int wa, input int wd,
                             input logic signed [15:0] es, input logic ec);
        int lat = -1;
        int bc = 0;
        @(negedge clk);
        ch_in = ch; ch_en = en; sample_stb = 1'b1;
        cfg_we = we; cfg_addr = 2'(wa); cfg_data = 8'(wd);
        #1 check({nm, "/overrun_idle"}, overrun, 0);
        @(negedge clk);
        sample_stb = 1'b0; cfg_we = 1'b0;
        ch_in = {$urandom, $urandom}; ch_en = 4'($urandom);
        if (we) gm[wa] = wd;
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge clk);
            if (busy) bc++;
            if (sound_valid) begin lat = n; break; end
        end
        check({nm, "/latency"}, lat, 5);
        check({nm, "/busy_cycles"}, bc, 4);
        check({nm, "/sound"}, longint'($signed(sound)), longint'(es));
        check({nm, "/clip"}, clip, ec);
        @(negedge clk);
        check({nm, "/valid_pulse"}, sound_valid, 0);
    endtask

    typedef struct {
        logic [63:0]        ch;
        logic [3:0]         en;
        logic [3:0]         gmask;
        int                 gw;
        logic signed [15:0] es;
        logic               ec;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic signed [15:0] es;
        logic               ec;
        logic [63:0]        a_in;
        int                 first, vcount;
        logic signed [15:0] sval;

        tbl[0] = '{pack4(0, -500, 2000, 1000), 4'b1111, 4'b0000, 0,   16'sd2500,  1'b0};
        tbl[1] = '{pack4(0, 0, 0, 1000),       4'b1111, 4'b0001, 64,  16'sd500,   1'b0};
        tbl[2] = '{pack4(0, 0, 0, 1000),       4'b1111, 4'b0001, 0,   16'sd0,     1'b0};
        tbl[3] = '{pack4(0, 0, 0, 1000),       4'b1111, 4'b0001, 255, 16'sd1992,  1'b0};
        tbl[4] = '{pack4(0, 0, 0, -1),         4'b1111, 4'b0001, 64,  -16'sd1,    1'b0};
        tbl[5] = '{pack4(32767, 32767, 32767, 32767),     4'b1111, 4'b1111, 255, 16'sd32767,  1'b1};
        tbl[6] = '{pack4(-32768, -32768, -32768, -32768), 4'b1111, 4'b0000, 0,   -16'sd32768, 1'b1};
        tbl[7] = '{pack4(0, 0, 0, 1000),       4'b1111, 4'b1111, 128, 16'sd1000,  1'b0};
        tbl[8] = '{pack4(100, 200, 300, 400),  4'b1101, 4'b0000, 0,   16'sd700,   1'b0};

        for (int i = 0; i < 4; i++) gm[i] = 128;
        rst_n = 1'b0; sample_stb = 1'b0; ch_in = '0; ch_en = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset/sound", sound, 0);
        check("reset/valid", sound_valid, 0);
        check("reset/clip", clip, 0);
        check("reset/busy", busy, 0);
        check("reset/overrun", overrun, 0);

        for (int t = 0; t < 9; t++) begin
            for (int c = 0; c < 4; c++)
                if (tbl[t].gmask[c]) write_gain(c, tbl[t].gw);
            do_sample($sformatf("tbl%0d", t), tbl[t].ch, tbl[t].en, 1'b0, 0, 0,
                      tbl[t].es, tbl[t].ec);
        end

        // Gain write coincident with the strobe lands in the following sample.
        do_sample("stb_write_old", pack4(0, 0, 0, 1000), 4'hf, 1'b1, 0, 64, 16'sd1000, 1'b0);
        do_sample("stb_write_new", pack4(0, 0, 0, 1000), 4'hf, 1'b0, 0, 0, 16'sd500, 1'b0);

        // Overrun: second strobe two cycles into the sample is dropped.
        a_in = pack4(0, 0, 0, 1000);
        model(a_in, 4'hf, es, ec);
        @(negedge clk);
        ch_in = a_in; ch_en = 4'hf; sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0; ch_in = pack4(0, 0, 0, 20000);
        @(negedge clk);
        sample_stb = 1'b1;
        #1 check("ovr/pulse", overrun, 1);
        @(negedge clk);
        sample_stb = 1'b0;
        #1 check("ovr/pulse_end", overrun, 0);
        first = -1; vcount = 0; sval = '0;
        for (int cyc = 3; cyc <= 12; cyc++) begin
            if (cyc > 3) @(negedge clk);
            if (sound_valid) begin
                vcount++;
                if (first < 0) begin first = cyc; sval = $signed(sound); end
            end
        end
        check("ovr/valid_cycle", first, 5);
        check("ovr/valid_count", vcount, 1);
        check("ovr/sound", longint'(sval), longint'(es));

        // Reset in the middle of a sample.
        @(negedge clk);
        ch_in = pack4(0, 0, 0, 1000); ch_en = 4'hf; sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst/sound", sound, 0);
        check("rst/busy", busy, 0);
        check("rst/valid", sound_valid, 0);
        check("rst/clip", clip, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) gm[i] = 128;
        vcount = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (sound_valid) vcount++;
        end
        check("rst/no_valid", vcount, 0);
        do_sample("rst_after", pack4(0, 0, 0, 1000), 4'hf, 1'b0, 0, 0, 16'sd1000, 1'b0);

        // Randomised samples against the reference model.
        for (int r = 0; r < 40; r++) begin
            logic [63:0] rch;
            logic [3:0]  ren;
            logic        rwe;
            int          rwa, rwd;
            if ($urandom_range(0, 1) == 1) write_gain($urandom_range(0, 3), $urandom_range(0, 255));
            rch = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) rch = rch >> 3;
            ren = 4'($urandom);
            rwe = ($urandom_range(0, 3) == 0);
            rwa = $urandom_range(0, 3);
            rwd = $urandom_range(0, 255);
            model(rch, ren, es, ec);
            do_sample($sformatf("rnd%0d", r), rch, ren, rwe, rwa, rwd, es, ec);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
